// File: rtl/mult_pkg.sv
// Shared definitions for the operand loader and the multiplier it feeds.
// Operand width and loader FSM state encoding live here.
package mult_pkg;

    localparam int OPERAND_W = 2;

    typedef enum logic [1:0] {
        ESPERA_A = 2'b00,
        ESPERA_B = 2'b01,
        VALIDO   = 2'b10
    } estado_t;

endpackage

// File: rtl/cargador_operandos_if.sv
// Operand pair handshake between the loader (master) and the multiplier
// result-capture logic (slave).
// Handshake: valido_o high means a_o/b_o hold a complete pair that stays
// stable until the slave raises listo_i for one or more cycles; the pair is
// consumed at the first rising edge where valido_o and listo_i are both high.
interface cargador_operandos_if #(
    parameter int WIDTH = mult_pkg::OPERAND_W
);
    logic [WIDTH-1:0] a_o;
    logic [WIDTH-1:0] b_o;
    logic             valido_o;
    logic             listo_i;

    modport master (
        output a_o,
        output b_o,
        output valido_o,
        input  listo_i
    );

    modport slave (
        input  a_o,
        input  b_o,
        input  valido_o,
        output listo_i
    );
endinterface

// File: rtl/cargador_operandos_antirrebote.sv
// Push-button conditioner: 2-flop synchroniser, debounce counter and a
// single-cycle pulse on each debounced press.
module antirrebote #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic boton_i,
    output logic pulso_o
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          sinc1_q;
    logic          sinc2_q;
    logic          nivel_q;
    logic          nivel_prev_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            sinc1_q      <= 1'b0;
            sinc2_q      <= 1'b0;
            nivel_q      <= 1'b0;
            nivel_prev_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            sinc1_q      <= boton_i;
            sinc2_q      <= sinc1_q;
            nivel_prev_q <= nivel_q;
            // The level flips only after the input has disagreed for
            // DEBOUNCE_CYCLES consecutive synchronised cycles.
            if (sinc2_q != nivel_q) begin
                if (cnt_q == CNT_MAX) begin
                    nivel_q <= ~nivel_q;
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign pulso_o = nivel_q & ~nivel_prev_q;

endmodule

// File: rtl/cargador_operandos.sv
// Loads two operands in sequence from a shared switch bus using a debounced
// button, then offers the pair downstream until it is acknowledged.
module cargador_operandos
    import mult_pkg::*;
#(
    parameter int WIDTH           = OPERAND_W,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic [WIDTH-1:0]     dato_i,
    input  logic                 cargar_i,
    cargador_operandos_if.master bus,
    output logic [1:0]           estado_o
);
    estado_t          estado_q;
    estado_t          estado_d;
    logic             pulso;
    logic             cap_a;
    logic             cap_b;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             valido_q;

    antirrebote #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_antirrebote (
        .clk_i  (clk_i),
        .rst_n_i(rst_n_i),
        .boton_i(cargar_i),
        .pulso_o(pulso)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            estado_q <= ESPERA_A;
            a_q      <= '0;
            b_q      <= '0;
            valido_q <= 1'b0;
        end else begin
            estado_q <= estado_d;
            valido_q <= (estado_d == VALIDO);
            if (cap_a) a_q <= dato_i;
            if (cap_b) b_q <= dato_i;
        end
    end

    always_comb begin
        estado_d = estado_q;
        cap_a    = 1'b0;
        cap_b    = 1'b0;
        case (estado_q)
            ESPERA_A: begin
                if (pulso) begin
                    cap_a    = 1'b1;
                    estado_d = ESPERA_B;
                end
            end
            ESPERA_B: begin
                if (pulso) begin
                    cap_b    = 1'b1;
                    estado_d = VALIDO;
                end
            end
            // Presses while a pair is pending are dropped, not queued.
            VALIDO: begin
                if (bus.listo_i) estado_d = ESPERA_A;
            end
            default: estado_d = ESPERA_A;
        endcase
    end

    assign bus.a_o      = a_q;
    assign bus.b_o      = b_q;
    assign bus.valido_o = valido_q;
    assign estado_o     = estado_q;

endmodule

// File: doc/cargador_operandos.md
Name: cargador_operandos

Overview:
Upstream stage of multiplicador. Captures the two 2-bit operands one after the other from a shared switch bus, using a debounced push-button to load each one. Presents the operand pair as a_o/b_o with a valid/acknowledge handshake, so the multiplier sees stable inputs only after both operands are loaded. Holds the pair until the downstream result-capture logic acknowledges it.

Parameters:
- WIDTH, 2, operand width in bits; a_o/b_o connect directly to a_i/b_i of multiplicador.
- DEBOUNCE_CYCLES, 4, number of consecutive cycles the synchronised button must differ from its debounced level before that level toggles; the board top overrides this with a larger value.

Ports:
- clk_i  input  1  system clock; all state updates on its rising edge.
- rst_n_i  input  1  reset, synchronous, active-low.
- dato_i  input  WIDTH  operand value from switches; sampled directly at the load edge.
- cargar_i  input  1  raw load push-button, active-high, asynchronous to clk_i.
- listo_i  input  1  downstream acknowledge; consumer has taken the current pair.
- a_o  output  WIDTH  operand A.
- b_o  output  WIDTH  operand B.
- valido_o  output  1  a_o/b_o hold a complete, stable pair.
- estado_o  output  2  FSM state for LEDs: 00 ESPERA_A, 01 ESPERA_B, 10 VALIDO.

Behaviour:
- Reset (rst_n_i=0 at a rising edge):
  - a_o=0, b_o=0, valido_o=0, estado_o=00.
  - Synchroniser flops, debounced level, previous level and debounce counter all clear to 0.
  - Reset mid-operation discards partial operands and any in-progress debounce count.
- Button conditioning:
  - cargar_i passes through a 2-flop synchroniser.
  - Counter increments every cycle the synchronised value differs from the debounced level; it clears whenever they are equal.
  - When the counter equals DEBOUNCE_CYCLES-1 and the values still differ, the level toggles at that edge and the counter clears.
  - Load pulse = level & ~level_prev. It is high for exactly one cycle per press. Release produces no pulse.
  - Glitches shorter than DEBOUNCE_CYCLES synchronised cycles produce no pulse.
- Latency: if cargar_i is first sampled high at edge 1 and stays high, the capture happens at edge DEBOUNCE_CYCLES+3 (edge 7 with the default).
- FSM:
  - ESPERA_A: on pulse, a_o<=dato_i and go to ESPERA_B.
  - ESPERA_B: on pulse, b_o<=dato_i, go to VALIDO, and set valido_o=1 at the same edge.
  - VALIDO: a_o/b_o/valido_o are held. Load pulses are ignored (dropped, not queued). If listo_i=1, go to ESPERA_A and valido_o<=0.
  - listo_i in ESPERA_A or ESPERA_B has no effect.
  - Pulse and listo_i in the same VALIDO cycle: go to ESPERA_A; the pulse is dropped.
- a_o/b_o retain their last values after leaving VALIDO and change only at a capture edge.
- The combinational product from multiplicador is only meaningful while valido_o=1.
- The unused encoding 11 returns to ESPERA_A on the next edge.

Decomposition:
- Package mult_pkg holds:
  - OPERAND_W=2;
  - estado_t enum (ESPERA_A=2'b00, ESPERA_B=2'b01, VALIDO=2'b10).
- multiplicador then also uses OPERAND_W from mult_pkg.
- One sub-module, antirrebote: synchroniser, debounce counter and rising-edge pulse. Parameter DEBOUNCE_CYCLES; ports clk_i, rst_n_i, boton_i, pulso_o.
- The FSM and operand registers stay in cargador_operandos.

Test Plan:
- Reset: hold rst_n_i=0 for 3 edges with cargar_i=1 -> a_o=0, b_o=0, valido_o=0, estado_o=00; no capture until 7 edges after release.
- Normal load:
  - dato_i=2'b11, hold cargar_i high from edge 1 -> a_o=3 at edge 7, estado_o=01.
  - Release, then dato_i=2'b10 and press again -> b_o=2, valido_o=1, estado_o=10; multiplicador m_o=4'b0110.
- Glitch rejection: cargar_i high for 2 cycles in ESPERA_A -> no capture, estado_o stays 00, a_o unchanged.
- Hold in VALIDO: with pair (3,2) valid, press again with dato_i=1 -> a_o=3, b_o=2, valido_o=1 unchanged.
- Handshake: listo_i=1 for one cycle in VALIDO -> valido_o=0 and estado_o=00 at next edge; a_o=3, b_o=2 retained. listo_i=1 in ESPERA_B -> no effect.
- Simultaneous / mid-reset:
  - Pulse and listo_i in the same cycle -> ESPERA_A, a_o unchanged.
  - Reset asserted in ESPERA_B -> estado_o=00, a_o=0, b_o=0 next edge.
